// File: rtl/debug_display_mux.sv
// Debug display source selector: shadow register file, PC, write count and last write,
// chosen by debounced board switches. Define DEBUG_DISP_PC_HIST_EN for a 4-deep PC history.
module debug_display_mux #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  debug_reg_write_en,
    input  logic [REG_ADDR_W-1:0] debug_reg_write_addr,
    input  logic [DATA_W-1:0]     debug_reg_write_data,
    input  logic [ADDR_W-1:0]     debug_pc_addr,
    input  logic [7:0]            switch,
    output logic [DATA_W-1:0]     disp_data,
    output logic                  disp_update,
    output logic                  frozen
);
    localparam int NREG  = 1 << REG_ADDR_W;
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [7:0]            sw_meta_q, sw_sync_q, sw_cand_q, sw_stable_q;
    logic [7:0]            sw_cand_d, sw_stable_d;
    logic [CNT_W-1:0]      deb_cnt_q, deb_cnt_d;
    logic [DATA_W-1:0]     shadow_q [NREG];
    logic [DATA_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]     last_wr_q, last_wr_d;
    logic [ADDR_W-1:0]     pc_q;
    logic [ADDR_W-1:0]     pc_view;
    logic [DATA_W-1:0]     disp_data_q, disp_data_d, sel_data;
    logic                  disp_update_q, disp_update_d;
    logic                  wr_acc;
    logic [REG_ADDR_W-1:0] sel_idx;

    assign wr_acc  = debug_reg_write_en && (debug_reg_write_addr != '0);
    assign sel_idx = REG_ADDR_W'(sw_stable_q[4:0]);

    // The whole switch vector must hold still for DEBOUNCE_CYC cycles before it is accepted.
    always_comb begin
        sw_cand_d   = sw_cand_q;
        deb_cnt_d   = deb_cnt_q;
        sw_stable_d = sw_stable_q;
        if (sw_sync_q != sw_cand_q) begin
            sw_cand_d = sw_sync_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q != CNT_MAX) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
        if (deb_cnt_q == CNT_MAX) begin
            sw_stable_d = sw_cand_q;
        end
    end

`ifdef DEBUG_DISP_PC_HIST_EN
    logic [ADDR_W-1:0] pc_hist_q [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pc_hist_q[i] <= '0;
        end else if (debug_pc_addr != pc_q) begin
            pc_hist_q[0] <= pc_q;
            for (int i = 1; i < 4; i++) pc_hist_q[i] <= pc_hist_q[i-1];
        end
    end

    always_comb begin
        pc_view = pc_q;
        if (sw_stable_q[1:0] != 2'd0) begin
            pc_view = pc_hist_q[sw_stable_q[1:0] - 2'd1];
        end
    end
`else
    assign pc_view = pc_q;
`endif

    // Counter and last-write views include this cycle's write, matching the shadow write-through.
    always_comb begin
        wr_cnt_d  = wr_cnt_q + DATA_W'(wr_acc);
        last_wr_d = wr_acc ? debug_reg_write_data : last_wr_q;
        sel_data  = '0;
        unique case (sw_stable_q[7:6])
            2'b00: sel_data = (wr_acc && (debug_reg_write_addr == sel_idx)) ?
                              debug_reg_write_data : shadow_q[sel_idx];
            2'b01: sel_data = DATA_W'(pc_view);
            2'b10: sel_data = wr_cnt_d;
            default: sel_data = last_wr_d;
        endcase
        disp_data_d   = sw_stable_q[5] ? disp_data_q : sel_data;
        disp_update_d = (disp_data_d != disp_data_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            sw_cand_q     <= '0;
            sw_stable_q   <= '0;
            deb_cnt_q     <= '0;
            wr_cnt_q      <= '0;
            last_wr_q     <= '0;
            pc_q          <= '0;
            disp_data_q   <= '0;
            disp_update_q <= 1'b0;
        end else begin
            sw_meta_q     <= switch;
            sw_sync_q     <= sw_meta_q;
            sw_cand_q     <= sw_cand_d;
            sw_stable_q   <= sw_stable_d;
            deb_cnt_q     <= deb_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            last_wr_q     <= last_wr_d;
            pc_q          <= debug_pc_addr;
            disp_data_q   <= disp_data_d;
            disp_update_q <= disp_update_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
        end else if (wr_acc) begin
            shadow_q[debug_reg_write_addr] <= debug_reg_write_data;
        end
    end

    assign disp_data   = disp_data_q;
    assign disp_update = disp_update_q;
    assign frozen      = sw_stable_q[5];
endmodule

// File: tb/tb_debug_display_mux.sv
// Directed bench for debug_display_mux with a short debounce window.
module tb_debug_display_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        debug_reg_write_en = 1'b0;
    logic [4:0]  debug_reg_write_addr = '0;
    logic [31:0] debug_reg_write_data = '0;
    logic [31:0] debug_pc_addr = 32'h0000_4000;
    logic [7:0]  switch = 8'h00;
    logic [31:0] disp_data;
    logic        disp_update;
    logic        frozen;

    int checks = 0;
    int errors = 0;

    debug_display_mux #(
        .DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .DEBOUNCE_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .debug_reg_write_en(debug_reg_write_en),
        .debug_reg_write_addr(debug_reg_write_addr),
        .debug_reg_write_data(debug_reg_write_data),
        .debug_pc_addr(debug_pc_addr),
        .switch(switch),
        .disp_data(disp_data),
        .disp_update(disp_update),
        .frozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        debug_reg_write_en   = 1'b1;
        debug_reg_write_addr = a;
        debug_reg_write_data = d;
        @(negedge clk);
        debug_reg_write_en   = 1'b0;
    endtask

    // Apply a switch setting and let it settle, counting display update pulses meanwhile.
    task automatic set_sw(input logic [7:0] v, output int pulses);
        pulses = 0;
        switch = v;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (disp_update) pulses++;
        end
    endtask

    task automatic test_reset;
        cycles(2);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL reset_disp got %h want %h", disp_data, 32'h0); end
        checks++; if (disp_update !== 1'b0) begin errors++; $display("FAIL reset_update got %b want 0", disp_update); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen got %b want 0", frozen); end
        @(negedge clk); rst = 1'b0;
        cycles(3);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL post_reset_disp got %h want %h", disp_data, 32'h0); end
    endtask

    task automatic test_debounce;
        int n;
        bit seen;
        @(negedge clk); switch = 8'h40;
        cycles(3);
        switch = 8'h00;
        cycles(10);
        checks++; if (dut.sw_stable_q !== 8'h00) begin errors++; $display("FAIL glitch_stable got %h want %h", dut.sw_stable_q, 8'h00); end
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL glitch_disp got %h want %h", disp_data, 32'h0); end
        switch = 8'h40;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (disp_data === 32'h0000_4000) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL debounce_pc got %h want %h", disp_data, 32'h0000_4000); end
    endtask

    task automatic test_shadow;
        int p;
        do_write(5'd5, 32'hDEAD_BEEF);
        cycles(2);
        checks++; if (disp_data !== 32'h0000_4000) begin errors++; $display("FAIL shadow_pc_hold got %h want %h", disp_data, 32'h0000_4000); end
        set_sw(8'h05, p);
        checks++; if (disp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL shadow_x5 got %h want %h", disp_data, 32'hDEAD_BEEF); end
        checks++; if (p !== 1) begin errors++; $display("FAIL shadow_pulses got %0d want 1", p); end
        do_write(5'd0, 32'h0000_1234);
        set_sw(8'h00, p);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL shadow_x0 got %h want %h", disp_data, 32'h0); end
        checks++; if (p !== 1) begin errors++; $display("FAIL shadow_x0_pulses got %0d want 1", p); end
    endtask

    task automatic test_write_through;
        int p;
        set_sw(8'h07, p);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL wt_before got %h want %h", disp_data, 32'h0); end
        do_write(5'd7, 32'h0000_55AA);
        checks++; if (disp_data !== 32'h0000_55AA) begin errors++; $display("FAIL wt_data got %h want %h", disp_data, 32'h0000_55AA); end
        checks++; if (disp_update !== 1'b1) begin errors++; $display("FAIL wt_update got %b want 1", disp_update); end
        @(negedge clk);
        checks++; if (disp_update !== 1'b0) begin errors++; $display("FAIL wt_update_clear got %b want 0", disp_update); end
    endtask

    task automatic test_counter;
        int p;
        switch = 8'h80;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        set_sw(8'h80, p);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL cnt_zero got %h want %h", disp_data, 32'h0); end
        do_write(5'd1, 32'h1);
        do_write(5'd1, 32'h2);
        do_write(5'd1, 32'h3);
        do_write(5'd0, 32'h4);
        cycles(1);
        checks++; if (disp_data !== 32'd3) begin errors++; $display("FAIL cnt_three got %h want %h", disp_data, 32'd3); end
        @(negedge clk);
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (disp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_preload got %h want %h", disp_data, 32'hFFFF_FFFF); end
        do_write(5'd2, 32'h9);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL cnt_wrap got %h want %h", disp_data, 32'h0); end
        checks++; if (disp_update !== 1'b1) begin errors++; $display("FAIL cnt_wrap_update got %b want 1", disp_update); end
        release dut.wr_cnt_q;
    endtask

    task automatic test_freeze;
        int p;
        bit bad;
        set_sw(8'hC0, p);
        do_write(5'd3, 32'h0000_00A5);
        checks++; if (disp_data !== 32'h0000_00A5) begin errors++; $display("FAIL frz_last got %h want %h", disp_data, 32'hA5); end
        set_sw(8'hE0, p);
        checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL frz_led got %b want 1", frozen); end
        do_write(5'd3, 32'h0000_005A);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (disp_data !== 32'h0000_00A5 || disp_update !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad) begin errors++; $display("FAIL frz_hold got %h/%b want %h/0", disp_data, disp_update, 32'hA5); end
        set_sw(8'hC0, p);
        checks++; if (disp_data !== 32'h0000_005A) begin errors++; $display("FAIL frz_release got %h want %h", disp_data, 32'h5A); end
        checks++; if (p !== 1) begin errors++; $display("FAIL frz_release_pulses got %0d want 1", p); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL frz_led_off got %b want 0", frozen); end
    endtask

    task automatic test_reset_mid;
        int p;
        do_write(5'd5, 32'hDEAD_BEEF);
        set_sw(8'h05, p);
        checks++; if (disp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_before got %h want %h", disp_data, 32'hDEAD_BEEF); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL mid_async got %h want %h", disp_data, 32'h0); end
        switch = 8'h00;
        @(negedge clk); rst = 1'b0;
        checks++; if (dut.sw_stable_q !== 8'h00) begin errors++; $display("FAIL mid_stable got %h want %h", dut.sw_stable_q, 8'h00); end
        checks++; if (dut.wr_cnt_q !== 32'h0) begin errors++; $display("FAIL mid_count got %h want %h", dut.wr_cnt_q, 32'h0); end
        checks++; if (dut.shadow_q[5] !== 32'h0) begin errors++; $display("FAIL mid_shadow got %h want %h", dut.shadow_q[5], 32'h0); end
        cycles(3);
        checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL mid_after got %h want %h", disp_data, 32'h0); end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_shadow;
        test_write_through;
        test_counter;
        test_freeze;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
